calc_key_seq: RTL and testbench

//  Sequential key-entry controller for the calculator. Accepts key events, builds decimal operands and

---
 rtl/calc_key_seq.sv | 207 ++++++++++++++++++++
 tb/tb_calc_key_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_key_seq.sv
// Key-entry sequencer: builds decimal operands from key events and launches the ALU.
// Optional ALU watchdog enabled by defining CALC_TIMEOUT_EN.
module calc_key_seq #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [1:0]       key_code,
    input  logic [3:0]       key_data,
    output logic [3:0]       state_code,
    output logic             code_valid,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [3:0]       op_sel,
    output logic             alu_start,
    input  logic             alu_done,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             err
);

    typedef enum logic [1:0] {
        ENTER_A = 2'b00,
        ENTER_B = 2'b01,
        SHOW    = 2'b10,
        BUSY    = 2'b11
    } state_t;

    localparam logic [1:0] K_CLR = 2'b00;
    localparam logic [1:0] K_DIG = 2'b01;
    localparam logic [1:0] K_OP  = 2'b10;
    localparam logic [1:0] K_EQ  = 2'b11;

    if (TIMEOUT < 1) begin : g_chk
        $error("calc_key_seq: TIMEOUT must be at least 1");
    end

    state_t state, state_nx;

    logic accept;
    logic dig_ok;
    logic expire;
    logic ovf;
    logic [WIDTH-1:0] x_sel;
    logic [WIDTH+3:0] x_mul;

    logic [WIDTH-1:0] op_a_nx, op_b_nx, result_nx;
    logic [3:0]       op_sel_nx, state_code_nx;
    logic             code_valid_nx, alu_start_nx;
    logic             result_valid_nx, err_nx;

    assign key_ready = (state != BUSY);
    assign accept    = key_valid & key_ready;
    assign dig_ok    = (key_data <= 4'd9);

    // Accumulate at WIDTH+4 bits so any wrap shows up in the top nibble.
    assign x_sel = (state == ENTER_B) ? op_b : op_a;
    assign x_mul = {4'b0000, x_sel} * (WIDTH+4)'(10)
                 + (WIDTH+4)'(key_data);
    assign ovf   = |x_mul[WIDTH+3:WIDTH];

`ifdef CALC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state != BUSY) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expire = (state == BUSY) && !alu_done
                 && (cnt == CW'(TIMEOUT - 1));
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ENTER_A;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ENTER_A: begin
                if (accept) begin
                    unique case (key_code)
                        K_OP:    state_nx = ENTER_B;
                        K_EQ:    state_nx = SHOW;
                        default: state_nx = ENTER_A;
                    endcase
                end
            end
            ENTER_B: begin
                if (accept && key_code == K_CLR) state_nx = ENTER_A;
                if (accept && key_code == K_EQ)  state_nx = BUSY;
            end
            SHOW: begin
                if (accept && key_code == K_CLR) state_nx = ENTER_A;
                if (accept && key_code == K_DIG && dig_ok) state_nx = ENTER_A;
            end
            BUSY: begin
                if (alu_done || expire) state_nx = SHOW;
            end
            default: state_nx = ENTER_A;
        endcase
    end

    always_comb begin
        op_a_nx         = op_a;
        op_b_nx         = op_b;
        op_sel_nx       = op_sel;
        result_nx       = result;
        state_code_nx   = state_code;
        code_valid_nx   = 1'b0;
        alu_start_nx    = 1'b0;
        result_valid_nx = 1'b0;
        err_nx          = 1'b0;
        if (accept) begin
            if (key_code == K_DIG && !dig_ok) begin
                err_nx = 1'b1;
            end else if (state == SHOW && key_code[1]) begin
                err_nx = 1'b1;
            end else begin
                code_valid_nx = 1'b1;
                state_code_nx = {state, key_code};
                unique case (key_code)
                    K_CLR: begin
                        op_a_nx   = '0;
                        op_b_nx   = '0;
                        op_sel_nx = '0;
                    end
                    K_DIG: begin
                        if (state == SHOW) begin
                            op_a_nx = WIDTH'(key_data);
                            op_b_nx = '0;
                        end else if (state == ENTER_A) begin
                            op_a_nx = x_mul[WIDTH-1:0];
                            err_nx  = ovf;
                        end else begin
                            op_b_nx = x_mul[WIDTH-1:0];
                            err_nx  = ovf;
                        end
                    end
                    K_OP: begin
                        op_sel_nx = key_data;
                        if (state == ENTER_A) op_b_nx = '0;
                    end
                    default: begin
                        if (state == ENTER_A) begin
                            result_nx       = op_a;
                            result_valid_nx = 1'b1;
                        end else begin
                            alu_start_nx = 1'b1;
                        end
                    end
                endcase
            end
        end else if (state == BUSY) begin
            if (alu_done) begin
                result_nx       = alu_result;
                result_valid_nx = 1'b1;
            end else if (expire) begin
                result_nx       = '0;
                result_valid_nx = 1'b1;
                err_nx          = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a         <= '0;
            op_b         <= '0;
            op_sel       <= '0;
            result       <= '0;
            state_code   <= '0;
            code_valid   <= 1'b0;
            alu_start    <= 1'b0;
            result_valid <= 1'b0;
            err          <= 1'b0;
        end else begin
            op_a         <= op_a_nx;
            op_b         <= op_b_nx;
            op_sel       <= op_sel_nx;
            result       <= result_nx;
            state_code   <= state_code_nx;
            code_valid   <= code_valid_nx;
            alu_start    <= alu_start_nx;
            result_valid <= result_valid_nx;
            err          <= err_nx;
        end
    end

endmodule

// File: tb/tb_calc_key_seq.sv
// Self-checking bench for calc_key_seq: directed scenarios plus random keys
// against an arithmetic reference model of the calculator.
module tb_calc_key_seq;

    localparam int W = 8;
    localparam logic [1:0] S_A = 2'd0;
    localparam logic [1:0] S_B = 2'd1;
    localparam logic [1:0] S_S = 2'd2;
    localparam logic [1:0] S_Y = 2'd3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [1:0]   key_code = '0;
    logic [3:0]   key_data = '0;
    logic [3:0]   state_code;
    logic         code_valid;
    logic [W-1:0] op_a, op_b, result;
    logic [3:0]   op_sel;
    logic         alu_start;
    logic         alu_done = 1'b0;
    logic [W-1:0] alu_result = '0;
    logic         result_valid;
    logic         err;

    int nerr = 0;
    int nchk = 0;

    logic [1:0] m_st;
    int         m_a, m_b, m_sel, m_res, m_code;

    calc_key_seq #(.WIDTH(W), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_valid(key_valid), .key_ready(key_ready),
        .key_code(key_code), .key_data(key_data),
        .state_code(state_code), .code_valid(code_valid),
        .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
        .alu_start(alu_start), .alu_done(alu_done),
        .alu_result(alu_result), .result(result),
        .result_valid(result_valid), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input bit e_err,
                             input bit e_cv, input bit e_st, input bit e_rv);
        chk({tag, ".op_a"}, int'(op_a), m_a);
        chk({tag, ".op_b"}, int'(op_b), m_b);
        chk({tag, ".op_sel"}, int'(op_sel), m_sel);
        chk({tag, ".result"}, int'(result), m_res);
        chk({tag, ".state_code"}, int'(state_code), m_code);
        chk({tag, ".code_valid"}, int'(code_valid), int'(e_cv));
        chk({tag, ".err"}, int'(err), int'(e_err));
        chk({tag, ".alu_start"}, int'(alu_start), int'(e_st));
        chk({tag, ".result_valid"}, int'(result_valid), int'(e_rv));
        chk({tag, ".key_ready"}, int'(key_ready), int'(m_st != S_Y));
    endtask

    task automatic model_reset();
        m_st = S_A; m_a = 0; m_b = 0; m_sel = 0; m_res = 0; m_code = 0;
    endtask

    task automatic press(input string tag, input logic [1:0] c,
                         input logic [3:0] d);
        bit e_err, e_cv, e_st, e_rv;
        int v;
        e_err = 0; e_cv = 0; e_st = 0; e_rv = 0;
        if (c == 2'd1 && d > 4'd9) begin
            e_err = 1;
        end else if (m_st == S_S && c >= 2'd2) begin
            e_err = 1;
        end else begin
            e_cv = 1;
            m_code = int'({m_st, c});
            case (c)
                2'd0: begin
                    m_a = 0; m_b = 0; m_sel = 0; m_st = S_A;
                end
                2'd1: begin
                    if (m_st == S_S) begin
                        m_a = int'(d); m_b = 0; m_st = S_A;
                    end else if (m_st == S_A) begin
                        v = m_a * 10 + int'(d);
                        e_err = (v > 255); m_a = v % 256;
                    end else begin
                        v = m_b * 10 + int'(d);
                        e_err = (v > 255); m_b = v % 256;
                    end
                end
                2'd2: begin
                    m_sel = int'(d);
                    if (m_st == S_A) begin
                        m_b = 0; m_st = S_B;
                    end
                end
                default: begin
                    if (m_st == S_A) begin
                        m_res = m_a; e_rv = 1; m_st = S_S;
                    end else begin
                        e_st = 1; m_st = S_Y;
                    end
                end
            endcase
        end
        @(negedge clk);
        key_valid = 1'b1; key_code = c; key_data = d;
        @(negedge clk);
        key_valid = 1'b0;
        check_all(tag, e_err, e_cv, e_st, e_rv);
    endtask

    task automatic alu(input string tag, input logic [W-1:0] r,
                       input int dly);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            chk({tag, ".busy_ready"}, int'(key_ready), 0);
            chk({tag, ".busy_rv"}, int'(result_valid), 0);
        end
        alu_done = 1'b1; alu_result = r;
        @(negedge clk);
        alu_done = 1'b0;
        m_res = int'(r); m_st = S_S;
        check_all(tag, 0, 0, 0, 1);
    endtask

    initial begin
        model_reset();
        #2;
        check_all("reset", 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        press("t1.d1", 2'd1, 4'd1);
        press("t1.d2", 2'd1, 4'd2);
        press("t1.op3", 2'd2, 4'd3);
        press("t1.d5", 2'd1, 4'd5);
        press("t1.eq", 2'd3, 4'd0);
        chk("t1.op_a12", int'(op_a), 12);
        chk("t1.code7", int'(state_code), 7);
        alu("t1.done", 8'd17, 2);
        chk("t1.res17", int'(result), 17);

        press("t2.clr", 2'd0, 4'd0);
        press("t2.d2", 2'd1, 4'd2);
        press("t2.d5", 2'd1, 4'd5);
        press("t2.d6", 2'd1, 4'd6);
        chk("t2.wrap", int'(op_a), 0);
        chk("t2.err", int'(err), 1);

        press("t4.badA", 2'd1, 4'hC);
        press("t3.eqA", 2'd3, 4'd0);
        press("t3.opS", 2'd2, 4'd1);
        press("t3.eqS", 2'd3, 4'd0);
        press("t3.badS", 2'd1, 4'hF);
        press("t3.d7", 2'd1, 4'd7);
        chk("t3.code9", int'(state_code), 9);
        press("t3.eqA2", 2'd3, 4'd0);
        press("t3.clrS", 2'd0, 4'd0);
        chk("t3.code8", int'(state_code), 8);

        press("b.d9", 2'd1, 4'd9);
        press("b.op", 2'd2, 4'd7);
        press("b.op2", 2'd2, 4'hE);
        press("b.bad", 2'd1, 4'hA);
        press("b.d3", 2'd1, 4'd3);
        press("b.clr", 2'd0, 4'd0);

`ifdef CALC_TIMEOUT_EN
        press("t5.op", 2'd2, 4'd1);
        press("t5.eq", 2'd3, 4'd0);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            chk("t5.wait_rv", int'(result_valid), 0);
        end
        @(negedge clk);
        m_res = 0; m_st = S_S;
        check_all("t5.expire", 1, 0, 0, 1);
        press("t5.d4", 2'd1, 4'd4);
        press("t5.op2", 2'd2, 4'd2);
        press("t5.eq2", 2'd3, 4'd0);
        repeat (14) @(negedge clk);
        alu_done = 1'b1; alu_result = 8'd99;
        @(negedge clk);
        alu_done = 1'b0;
        m_res = 99; m_st = S_S;
        check_all("t5.lastcyc", 0, 0, 0, 1);
`else
        press("t5.op", 2'd2, 4'd1);
        press("t5.eq", 2'd3, 4'd0);
        repeat (20) @(negedge clk);
        chk("t5.still_busy", int'(key_ready), 0);
        alu("t5.late_done", 8'd42, 0);
`endif

        press("t6.clr", 2'd0, 4'd0);
        press("t6.d8", 2'd1, 4'd8);
        press("t6.op", 2'd2, 4'd4);
        press("t6.d1", 2'd1, 4'd1);
        press("t6.eq", 2'd3, 4'd0);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t6.rst", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        alu_done = 1'b1; alu_result = 8'd55;
        @(negedge clk);
        alu_done = 1'b0;
        check_all("t6.late", 0, 0, 0, 0);

        for (int n = 0; n < 300; n++) begin
            logic [1:0] c;
            logic [3:0] d;
            c = 2'($urandom_range(0, 3));
            if (c == 2'd1 && $urandom_range(0, 7) != 0)
                d = 4'($urandom_range(0, 9));
            else
                d = 4'($urandom_range(0, 15));
            press("rnd.key", c, d);
            if (m_st == S_Y) begin
                alu("rnd.alu", 8'($urandom_range(0, 255)),
                    int'($urandom_range(0, 5)));
            end else if ($urandom_range(0, 9) == 0) begin
                alu_done = 1'b1; alu_result = 8'($urandom_range(0, 255));
                @(negedge clk);
                alu_done = 1'b0;
                check_all("rnd.idle_done", 0, 0, 0, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
